// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one shift-add multiplier between two requesters.
// Optional feature: define MULT_ARBITER_ZERO_BYPASS_EN to answer zero-operand requests directly.
module mult_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req_a0,
  input  logic [WIDTH-1:0]     req_b0,
  input  logic [WIDTH-1:0]     req_a1,
  input  logic [WIDTH-1:0]     req_b1,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [2*WIDTH-1:0]   resp_product,
  output logic                 busy,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  output logic                 mult_start,
  input  logic [2*WIDTH-1:0]   mult_product
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StDone} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 grant_id_q, grant_id_d;
  logic                 last_grant_q, last_grant_d;
  logic [WIDTH-1:0]     mult_a_q, mult_a_d;
  logic [WIDTH-1:0]     mult_b_q, mult_b_d;
  logic                 mult_start_q, mult_start_d;
  logic [2*WIDTH-1:0]   resp_product_q, resp_product_d;

  logic                 winner;
  logic                 req_fire;
  logic [WIDTH-1:0]     sel_a;
  logic [WIDTH-1:0]     sel_b;

  // With both requesters pending, the one not granted last time wins.
  always_comb begin
    winner = 1'b0;
    unique case (req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant_q;
      default: winner = 1'b0;
    endcase
  end

  assign req_fire = (state_q == StIdle) && (|req_valid);
  assign sel_a    = winner ? req_a1 : req_a0;
  assign sel_b    = winner ? req_b1 : req_b0;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    grant_id_d     = grant_id_q;
    last_grant_d   = last_grant_q;
    mult_a_d       = mult_a_q;
    mult_b_d       = mult_b_q;
    mult_start_d   = 1'b0;
    resp_product_d = resp_product_q;

    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          mult_a_d     = sel_a;
          mult_b_d     = sel_b;
          grant_id_d   = winner;
          last_grant_d = winner;
`ifdef MULT_ARBITER_ZERO_BYPASS_EN
          if ((sel_a == '0) || (sel_b == '0)) begin
            state_d        = StDone;
            resp_product_d = '0;
          end else begin
            state_d      = StStart;
            mult_start_d = 1'b1;
          end
`else
          state_d      = StStart;
          mult_start_d = 1'b1;
`endif
        end
      end
      StStart: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        // The multiplier result is settled on the last wait cycle.
        if (cnt_q == CntMax) begin
          resp_product_d = mult_product;
          state_d        = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (resp_ready[grant_id_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      grant_id_q     <= 1'b0;
      last_grant_q   <= 1'b1;
      mult_a_q       <= '0;
      mult_b_q       <= '0;
      mult_start_q   <= 1'b0;
      resp_product_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      grant_id_q     <= grant_id_d;
      last_grant_q   <= last_grant_d;
      mult_a_q       <= mult_a_d;
      mult_b_q       <= mult_b_d;
      mult_start_q   <= mult_start_d;
      resp_product_q <= resp_product_d;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (req_fire) begin
      req_ready = winner ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    resp_valid = 2'b00;
    if (state_q == StDone) begin
      resp_valid = grant_id_q ? 2'b10 : 2'b01;
    end
  end

  assign busy         = (state_q != StIdle);
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;
  assign mult_start   = mult_start_q;
  assign resp_product = resp_product_q;

  a_req_ready_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));
  a_resp_valid_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(resp_valid));
  a_start_only_in_start : assert property (@(posedge clk) disable iff (!rst_n)
    mult_start |-> (state_q == StStart));

endmodule
